data_memory_responder: RTL and testbench
========================================

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to response valid; legal range 1..15.
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning the number of 32-bit words in the storage array.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports clk and reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data.
REQ-011 req_wstrb  input  4  byte enables; bit i enables byte lane i (bits 8i+7:8i).
REQ-012 resp_valid  output  1  response present.
REQ-013 resp_ready  input  1  initiator accepts the response.
REQ-014 resp_rdata  output  32  load data; 0 for stores and for errors.
REQ-015 resp_error  output  1  request was misaligned or out of range.
REQ-016 initial_values  input  32 x DEPTH  word array loaded into storage during reset.
REQ-017 memory_check  output  32 x DEPTH  combinational view of the storage array, for test.

Function
REQ-018 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-019 req_ready SHALL be 1 exactly when state is IDLE.
REQ-020 In IDLE with req_valid=1, the block SHALL latch req_write, req_addr, req_wdata and req_wstrb into internal registers at the clock edge.
REQ-021 At the same edge, the block SHALL load the latency counter with LATENCY-1 and enter WAIT; request inputs are ignored outside IDLE.
REQ-022 In WAIT, a counter value of 0 SHALL move the FSM to RESP at the next edge; otherwise the counter SHALL decrement by 1 per cycle.
REQ-023 resp_valid SHALL therefore first be 1 in the cycle that follows the LATENCY-th rising edge after the accepting edge.
REQ-024 Word index SHALL be addr[log2(DEPTH)+1:2].
REQ-025 A request is an error when addr[1:0] != 0 or addr >= 4*DEPTH.
REQ-026 On the WAIT-to-RESP edge, a non-error store SHALL update the enabled bytes only; disabled bytes keep their value; wstrb=0 SHALL leave memory unchanged with resp_error=0.
REQ-027 On the WAIT-to-RESP edge, a non-error load SHALL register the current word into resp_rdata.
REQ-028 An error request SHALL perform no write and SHALL register resp_rdata=0 and resp_error=1.
REQ-029 resp_valid, resp_rdata and resp_error SHALL hold stable in RESP until resp_ready=1.
REQ-030 On an edge with resp_valid and resp_ready both 1, the FSM SHALL return to IDLE, clear resp_valid, resp_rdata and resp_error to 0, and raise req_ready in the following cycle; there is no same-cycle back-to-back acceptance.
REQ-031 resp_ready SHALL be ignored outside RESP.
REQ-032 req_wstrb SHALL be ignored for loads.
REQ-033 A load issued after a completed store to the same word SHALL return the stored data.

Reset
REQ-034 With reset=1 at an edge, the state SHALL become IDLE, the counter 0, resp_valid 0, resp_rdata 0, resp_error 0, and mem[i] initial_values[i] for all i.
REQ-035 reset SHALL take priority over all other activity; a transaction in WAIT or RESP is abandoned with no memory write.
REQ-036 req_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-037 Load with LATENCY=2 and initial_values[3]=0xDEADBEEF: load addr 0x0C accepted at edge T -> resp_valid=1 after edge T+2, rdata=0xDEADBEEF, error=0, req_ready=0 in between.
REQ-038 Partial store: mem[1]=0x11223344, store addr 0x04 wdata=0xAABBCCDD wstrb=4'b0101 -> memory_check[1]=0x11BB33DD; a later load of 0x04 returns 0x11BB33DD.
REQ-039 Errors: load 0x06 -> error=1, rdata=0; store to 0x80 with DEPTH=32 -> error=1 and memory_check unchanged.
REQ-040 Backpressure: resp_ready held 0 for 5 cycles -> response fields stable, req_ready=0, a new req_valid is ignored; resp_ready=1 -> IDLE next cycle.
REQ-041 Reset mid-WAIT during a store to 0x08 -> no write, memory_check equals initial_values, req_ready=1 the cycle after reset deasserts.
REQ-042 LATENCY=1: accept at edge T -> resp_valid=1 after edge T+1.

Source files
------------

// File: rtl/data_memory_responder_if.sv
// Request/response bus between a load/store initiator and the data memory.
interface data_memory_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_addr,
    output req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    input  req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid,
    output resp_rdata, resp_error
  );
endinterface

// File: rtl/data_memory_responder.sv
// Word-addressed data memory with fixed-latency single-outstanding responses.
module data_memory_responder #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  data_memory_responder_if.slave bus,
  input  logic [DEPTH-1:0][31:0] initial_values,
  output logic [DEPTH-1:0][31:0] memory_check
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_rdata;
  logic        r_error;
  logic [31:0] r_mem [DEPTH];

  logic          w_accept;
  logic          w_fire;
  logic          w_done;
  logic          w_err;
  logic [AW-1:0] w_idx;

  assign w_idx    = r_addr[AW+1:2];
  assign w_err    = (r_addr[1:0] != 2'b00) || (r_addr >= LIMIT);
  assign w_accept = (r_state == S_IDLE) && bus.req_valid;
  assign w_fire   = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_done   = (r_state == S_RESP) && bus.resp_ready;

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_error = r_error;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      memory_check[i] = r_mem[i];
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = S_WAIT;
      S_WAIT: if (w_fire)   w_next = S_RESP;
      S_RESP: if (w_done)   w_next = S_IDLE;
      default:              w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
      r_error <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= initial_values[i];
      end
    end else begin
      if (w_accept) begin
        r_write <= bus.req_write;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_wstrb <= bus.req_wstrb;
        r_cnt   <= 4'(LATENCY - 1);
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Memory side effect and response data happen together on WAIT->RESP.
      if (w_fire) begin
        if (w_err) begin
          r_rdata <= '0;
          r_error <= 1'b1;
        end else if (r_write) begin
          r_rdata <= '0;
          r_error <= 1'b0;
          for (int b = 0; b < 4; b++) begin
            if (r_wstrb[b]) r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
          end
        end else begin
          r_rdata <= r_mem[w_idx];
          r_error <= 1'b0;
        end
      end
      if (w_done) begin
        r_rdata <= '0;
        r_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder (LATENCY=2 main, LATENCY=1 side).
module tb_data_memory_responder;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_memory_responder_if bus ();
  data_memory_responder_if bus1 ();

  logic [DEPTH-1:0][31:0] iv;
  logic [DEPTH-1:0][31:0] mchk;
  logic [DEPTH-1:0][31:0] mchk1;

  data_memory_responder #(.LATENCY(2), .DEPTH(DEPTH)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus.slave),
    .initial_values (iv),
    .memory_check   (mchk)
  );

  data_memory_responder #(.LATENCY(1), .DEPTH(DEPTH)) u_dut1 (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus1.slave),
    .initial_values (iv),
    .memory_check   (mchk1)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] exp_mem [DEPTH];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    for (int i = 0; i < DEPTH; i++) chk(tag, mchk[i], exp_mem[i]);
  endtask

  function automatic exp_t model(input logic w, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [3:0] ws);
    exp_t e;
    e.rdata = '0;
    e.err   = (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
    if (!e.err) begin
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (ws[b]) exp_mem[a[6:2]][8*b +: 8] = wd[8*b +: 8];
      end else begin
        e.rdata = exp_mem[a[6:2]];
      end
    end
    return e;
  endfunction

  task automatic do_req(input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws,
                        input int hold);
    exp_t e;
    int   n;
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_wstrb = ws;
    sb.push_back(model(w, a, wd, ws));
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      chk("req_ready_wait", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'd2);
    e = sb.pop_front();
    chk("rdata", bus.resp_rdata, e.rdata);
    chk("error", 32'(bus.resp_error), 32'(e.err));
    for (int k = 0; k < hold; k++) begin
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 32'h0;
      bus.req_wdata = 32'hFFFF_FFFF;
      bus.req_wstrb = 4'hF;
      @(posedge clk); #1;
      chk("bp_valid", 32'(bus.resp_valid), 32'd1);
      chk("bp_rdata", bus.resp_rdata, e.rdata);
      chk("bp_error", 32'(bus.resp_error), 32'(e.err));
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("post_valid", 32'(bus.resp_valid), 32'd0);
    chk("post_req_ready", 32'(bus.req_ready), 32'd1);
    chk("post_rdata", bus.resp_rdata, 32'd0);
    chk("post_error", 32'(bus.resp_error), 32'd0);
  endtask

  initial begin : main
    logic [31:0] a;
    logic        w;
    for (int i = 0; i < DEPTH; i++) iv[i] = $urandom;
    iv[3] = 32'hDEAD_BEEF;
    iv[1] = 32'h1122_3344;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = iv[i];
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.req_wstrb   = '0;
    bus.resp_ready  = 1'b0;
    bus1.req_valid  = 1'b0;
    bus1.req_write  = 1'b0;
    bus1.req_addr   = '0;
    bus1.req_wdata  = '0;
    bus1.req_wstrb  = '0;
    bus1.resp_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_error", 32'(bus.resp_error), 32'd0);
    chk_mem("rst_mem");

    do_req(1'b0, 32'h0C, 32'h0, 4'h0, 0);
    do_req(1'b1, 32'h04, 32'hAABB_CCDD, 4'b0101, 0);
    chk("partial_mem", mchk[1], 32'h11BB_33DD);
    do_req(1'b0, 32'h04, 32'h0, 4'h0, 0);
    do_req(1'b0, 32'h06, 32'h0, 4'h0, 0);
    do_req(1'b1, 32'h80, 32'h5555_5555, 4'hF, 0);
    chk_mem("oob_store_mem");
    do_req(1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 0);
    chk_mem("zero_strb_mem");
    do_req(1'b0, 32'h0C, 32'h0, 4'hF, 5);
    chk_mem("bp_ignored_mem");
    do_req(1'b1, 32'h7C, 32'hCAFE_F00D, 4'hF, 0);
    do_req(1'b0, 32'h7C, 32'h0, 4'h0, 0);
    do_req(1'b0, 32'h7D, 32'h0, 4'h0, 0);
    do_req(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 0);

    for (int t = 0; t < 24; t++) begin
      a = 32'($urandom_range(0, 37)) * 32'd4;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      w = 1'($urandom_range(0, 1));
      do_req(w, a, $urandom, 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 2)));
    end
    chk_mem("random_mem");

    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h08;
    bus.req_wdata = 32'h1234_5678;
    bus.req_wstrb = 4'hF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("midwait_req_ready", 32'(bus.req_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = iv[i];
    chk("rst2_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst2_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk_mem("rst2_mem");
    repeat (3) @(posedge clk);
    #1;
    chk("rst2_idle_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst2_word2", mchk[2], iv[2]);

    bus1.req_valid = 1'b1;
    bus1.req_addr  = 32'h0C;
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    chk("lat1_wait_valid", 32'(bus1.resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat1_valid", 32'(bus1.resp_valid), 32'd1);
    chk("lat1_rdata", bus1.resp_rdata, 32'hDEAD_BEEF);
    bus1.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus1.resp_ready = 1'b0;
    chk("lat1_done", 32'(bus1.req_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
